csr_regfile: RTL

- Machine-mode CSR register file for the 64-bit pipelined core.
- Commits the new CSR value that the EX-stage CSR ALU computed. That value arrives through the WB write port.
- Serves combinational CSR reads to EX, performs trap entry and mret state updates, runs the cycle and instret counters, and raises the timer-interrupt request.

---
 rtl/csr_if.sv | 38 +++
 rtl/csr_regfile.sv | 137 +++++++++++++
 2 files changed

// File: rtl/csr_if.sv
// CSR port bundle: EX read port, WB write port, trap/mret control and
// the outputs the pipeline consumes.
interface csr_if #(
  parameter int unsigned XLEN = 64
);
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            retire;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_tval;
  logic            mret;
  logic            timer_irq;
  logic [XLEN-1:0] trap_vec;
  logic [XLEN-1:0] mepc_out;
  logic            irq_pending;

  modport master (
    output csr_raddr, csr_we, csr_waddr, csr_wdata,
    output retire, trap_valid, trap_pc, trap_cause,
    output trap_tval, mret, timer_irq,
    input  csr_rdata, csr_illegal, trap_vec,
    input  mepc_out, irq_pending
  );

  modport slave (
    input  csr_raddr, csr_we, csr_waddr, csr_wdata,
    input  retire, trap_valid, trap_pc, trap_cause,
    input  trap_tval, mret, timer_irq,
    output csr_rdata, csr_illegal, trap_vec,
    output mepc_out, irq_pending
  );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: WARL writes, trap/mret updates, counters and
// the registered timer/software interrupt request.
module csr_regfile #(
  parameter int unsigned XLEN   = 64,
  parameter logic [63:0] HARTID = 64'd0
) (
  input logic  clk,
  input logic  rstn,
  csr_if.slave bus
);
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  logic            mst_mie, mst_mpie;
  logic            mie_msie, mie_mtie, mie_meie;
  logic            mip_msip, mip_mtip;
  logic [XLEN-1:0] mtvec, mscratch, mepc;
  logic [XLEN-1:0] mcause, mtval;
  logic [XLEN-1:0] mcycle, minstret;
  logic            irq_q;
  logic            wr;
  logic [XLEN-1:0] wd;
  logic [XLEN-1:0] mstatus_v, mie_v, mip_v;
  logic [XLEN-1:0] base;

  // trap and mret both suppress the WB write entirely
  assign wr = bus.csr_we & ~bus.trap_valid & ~bus.mret;
  assign wd = bus.csr_wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
      mie_msie <= 1'b0;
      mie_mtie <= 1'b0;
      mie_meie <= 1'b0;
      mip_msip <= 1'b0;
      mip_mtip <= 1'b0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      mcycle   <= '0;
      minstret <= '0;
      irq_q    <= 1'b0;
    end else begin
      mip_mtip <= bus.timer_irq;
      irq_q    <= mst_mie & ((mie_mtie & mip_mtip) |
                             (mie_msie & mip_msip));
      mcycle   <= (wr && bus.csr_waddr == A_MCYCLE) ?
                  wd : mcycle + 1'b1;
      minstret <= (wr && bus.csr_waddr == A_MINSTRET) ?
                  wd : minstret + XLEN'(bus.retire);
      if (bus.trap_valid) begin
        mepc     <= {bus.trap_pc[XLEN-1:2], 2'b00};
        mcause   <= bus.trap_cause;
        mtval    <= bus.trap_tval;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (bus.mret) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (wr) begin
        case (bus.csr_waddr)
          A_MSTATUS: begin
            mst_mie  <= wd[3];
            mst_mpie <= wd[7];
          end
          A_MIE: begin
            mie_msie <= wd[3];
            mie_mtie <= wd[7];
            mie_meie <= wd[11];
          end
          A_MTVEC:    mtvec    <= {wd[XLEN-1:2], 1'b0, wd[0]};
          A_MSCRATCH: mscratch <= wd;
          A_MEPC:     mepc     <= {wd[XLEN-1:2], 2'b00};
          A_MCAUSE:   mcause   <= wd;
          A_MTVAL:    mtval    <= wd;
          A_MIP:      mip_msip <= wd[3];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mstatus_v        = '0;
    mstatus_v[12:11] = 2'b11;
    mstatus_v[7]     = mst_mpie;
    mstatus_v[3]     = mst_mie;
    mie_v            = '0;
    mie_v[11]        = mie_meie;
    mie_v[7]         = mie_mtie;
    mie_v[3]         = mie_msie;
    mip_v            = '0;
    mip_v[7]         = mip_mtip;
    mip_v[3]         = mip_msip;
  end

  always_comb begin
    bus.csr_rdata   = '0;
    bus.csr_illegal = 1'b0;
    case (bus.csr_raddr)
      A_MSTATUS:  bus.csr_rdata = mstatus_v;
      A_MIE:      bus.csr_rdata = mie_v;
      A_MTVEC:    bus.csr_rdata = mtvec;
      A_MSCRATCH: bus.csr_rdata = mscratch;
      A_MEPC:     bus.csr_rdata = mepc;
      A_MCAUSE:   bus.csr_rdata = mcause;
      A_MTVAL:    bus.csr_rdata = mtval;
      A_MIP:      bus.csr_rdata = mip_v;
      A_MCYCLE:   bus.csr_rdata = mcycle;
      A_MINSTRET: bus.csr_rdata = minstret;
      A_MHARTID:  bus.csr_rdata = XLEN'(HARTID);
      default:    bus.csr_illegal = 1'b1;
    endcase
  end

  // vectored mode only offsets interrupts, never exceptions
  assign base = {mtvec[XLEN-1:2], 2'b00};
  assign bus.trap_vec =
    (mtvec[0] & bus.trap_cause[XLEN-1]) ?
    base + XLEN'({bus.trap_cause[5:0], 2'b00}) : base;

  assign bus.mepc_out    = mepc;
  assign bus.irq_pending = irq_q;
endmodule
